// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding used by both the master and the
// subordinate, plus the default subordinate bus address.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX        = 3'd3,
    RX_ACK    = 3'd4,
    TX        = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h01;

  // Debug ports carry the state zero-extended to 4 bits.
  function automatic logic [3:0] state_code(input i2c_state_e s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Registers SCL/SDA from the shared bus and derives SCL edge strobes and
// START/STOP conditions (SDA edges while SCL is stably high).
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_d_o,
  output logic scl_posedge_o,
  output logic scl_negedge_o,
  output logic start_o,
  output logic stop_o
);

  logic scl_q;
  logic sda_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 1'b0;
      sda_q <= 1'b0;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
    end
  end

  assign scl_d_o       = scl_q;
  assign scl_posedge_o = scl_i & ~scl_q;
  assign scl_negedge_o = ~scl_i & scl_q;
  // Requiring SCL high on both samples keeps a data change that races an SCL
  // edge from being mistaken for a bus condition.
  assign start_o       = scl_i & scl_q & sda_q & ~sda_i;
  assign stop_o        = scl_i & scl_q & ~sda_q & sda_i;

endmodule

// File: rtl/i2c_subordinate.sv
// I2C target with a fixed 7-bit address: receives single bytes on writes and
// returns data_in on reads. Internal state is exported on debug ports.
module i2c_subordinate
  import i2c_pkg::*;
#(
  parameter logic [6:0] SUB_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk_400,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       next_byte_1,
  output logic       data_ready,
  output logic       rw,
  output logic [3:0] state_out,
  output logic [7:0] data_reg,
  output logic [7:0] addr_reg,
  output logic [2:0] data_bit,
  output logic [2:0] addr_bit,
  output logic       addr_match,
  output logic       scl_posedge,
  output logic       scl_negedge,
  output logic       last_addr_bit_done,
  output logic       last_data_bit_done,
  output logic       SCL_d,
  output logic       next_byte
);

  i2c_state_e state_q, state_d;
  logic [7:0] addr_reg_q, addr_reg_d;
  logic [7:0] data_reg_q, data_reg_d;
  logic [2:0] addr_bit_q, addr_bit_d;
  logic [2:0] data_bit_q, data_bit_d;
  logic       rw_q, rw_d;
  logic       addr_match_q, addr_match_d;
  logic [7:0] data_out_q, data_out_d;
  logic       next_byte_q, next_byte_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_phase_q, ack_phase_d;
  logic       data_ready_q, data_ready_d;
  logic       last_addr_q, last_addr_d;
  logic       last_data_q, last_data_d;

  logic sda_in;
  logic scl_pos, scl_neg, bus_start, bus_stop;

  assign sda_in = SDA;
  assign SDA    = sda_oe_q ? 1'b0 : 1'bz;

  i2c_bus_sync u_bus_sync (
    .clk_i         (clk_400),
    .rst_ni        (rst_n),
    .scl_i         (SCL),
    .sda_i         (sda_in),
    .scl_d_o       (SCL_d),
    .scl_posedge_o (scl_pos),
    .scl_negedge_o (scl_neg),
    .start_o       (bus_start),
    .stop_o        (bus_stop)
  );

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_reg_q   <= 8'h00;
      data_reg_q   <= 8'h00;
      addr_bit_q   <= 3'd7;
      data_bit_q   <= 3'd7;
      rw_q         <= 1'b0;
      addr_match_q <= 1'b0;
      data_out_q   <= 8'h00;
      next_byte_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      ack_phase_q  <= 1'b0;
      data_ready_q <= 1'b0;
      last_addr_q  <= 1'b0;
      last_data_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_reg_q   <= addr_reg_d;
      data_reg_q   <= data_reg_d;
      addr_bit_q   <= addr_bit_d;
      data_bit_q   <= data_bit_d;
      rw_q         <= rw_d;
      addr_match_q <= addr_match_d;
      data_out_q   <= data_out_d;
      next_byte_q  <= next_byte_d;
      sda_oe_q     <= sda_oe_d;
      ack_phase_q  <= ack_phase_d;
      data_ready_q <= data_ready_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
    end
  end

  // SDA is sampled on SCL rising and the drive only changes on SCL falling.
  // ack_phase_q marks the second half of an ACK slot (ACK already driven, or
  // in TX_ACK: master ACK seen and next byte loaded).
  always_comb begin
    state_d      = state_q;
    addr_reg_d   = addr_reg_q;
    data_reg_d   = data_reg_q;
    addr_bit_d   = addr_bit_q;
    data_bit_d   = data_bit_q;
    rw_d         = rw_q;
    addr_match_d = addr_match_q;
    data_out_d   = data_out_q;
    next_byte_d  = next_byte_q;
    sda_oe_d     = sda_oe_q;
    ack_phase_d  = ack_phase_q;
    data_ready_d = 1'b0;
    last_addr_d  = 1'b0;
    last_data_d  = 1'b0;

    case (state_q)
      IDLE, WAIT_STOP: begin
      end
      ADDR: if (scl_pos) begin
        addr_reg_d = {addr_reg_q[6:0], sda_in};
        addr_bit_d = addr_bit_q - 3'd1;
        if (addr_bit_q == 3'd0) begin
          last_addr_d  = 1'b1;
          rw_d         = sda_in;
          addr_match_d = (addr_reg_q[6:0] == SUB_ADDR);
          ack_phase_d  = 1'b0;
          state_d      = (addr_reg_q[6:0] == SUB_ADDR) ? ADDR_ACK : IDLE;
        end
      end
      ADDR_ACK: if (scl_neg) begin
        if (!ack_phase_q) begin
          sda_oe_d    = 1'b1;
          ack_phase_d = 1'b1;
        end else begin
          ack_phase_d = 1'b0;
          data_bit_d  = 3'd7;
          if (rw_q) begin
            data_reg_d = data_in;
            sda_oe_d   = ~data_in[7];
            state_d    = TX;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = RX;
          end
        end
      end
      RX: if (scl_pos) begin
        data_reg_d = {data_reg_q[6:0], sda_in};
        data_bit_d = data_bit_q - 3'd1;
        if (data_bit_q == 3'd0) begin
          // data_ready is a one-cycle strobe qualifying data_out; no back-pressure.
          last_data_d  = 1'b1;
          data_out_d   = {data_reg_q[6:0], sda_in};
          data_ready_d = 1'b1;
          ack_phase_d  = 1'b0;
          state_d      = RX_ACK;
        end
      end
      RX_ACK: if (scl_neg) begin
        if (!ack_phase_q) begin
          sda_oe_d    = 1'b1;
          ack_phase_d = 1'b1;
          next_byte_d = next_byte_1;
        end else begin
          sda_oe_d    = 1'b0;
          ack_phase_d = 1'b0;
          data_bit_d  = 3'd7;
          state_d     = RX;
        end
      end
      TX: if (scl_neg) begin
        if (data_bit_q == 3'd0) begin
          last_data_d = 1'b1;
          sda_oe_d    = 1'b0;
          ack_phase_d = 1'b0;
          data_bit_d  = 3'd7;
          state_d     = TX_ACK;
        end else begin
          data_bit_d = data_bit_q - 3'd1;
          data_reg_d = {data_reg_q[6:0], 1'b0};
          sda_oe_d   = ~data_reg_q[6];
        end
      end
      TX_ACK: begin
        if (scl_pos && !ack_phase_q) begin
          if (!sda_in) begin
            data_reg_d  = data_in;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WAIT_STOP;
          end
        end else if (scl_neg && ack_phase_q) begin
          sda_oe_d    = ~data_reg_q[7];
          ack_phase_d = 1'b0;
          data_bit_d  = 3'd7;
          state_d     = TX;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus_start) begin
      state_d      = ADDR;
      addr_bit_d   = 3'd7;
      data_bit_d   = 3'd7;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      ack_phase_d  = 1'b0;
    end else if (bus_stop) begin
      state_d     = IDLE;
      data_bit_d  = 3'd7;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
    end
  end

  assign state_out          = state_code(state_q);
  assign data_out           = data_out_q;
  assign data_ready         = data_ready_q;
  assign rw                 = rw_q;
  assign data_reg           = data_reg_q;
  assign addr_reg           = addr_reg_q;
  assign data_bit           = data_bit_q;
  assign addr_bit           = addr_bit_q;
  assign addr_match         = addr_match_q;
  assign scl_posedge        = scl_pos;
  assign scl_negedge        = scl_neg;
  assign last_addr_bit_done = last_addr_q;
  assign last_data_bit_done = last_data_q;
  assign next_byte          = next_byte_q;

endmodule

// File: tb/tb_i2c_subordinate.sv
// Bench for i2c_subordinate: a task-level I2C master drives the bus and each
// scenario task checks the DUT against a transaction-level expectation model.
module tb_i2c_subordinate;

  logic       clk_400 = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_oe;
  logic [7:0] data_in;
  logic       next_byte_1;
  wire        SDA;

  logic [7:0] data_out, data_reg, addr_reg;
  logic       data_ready, rw, addr_match, scl_posedge, scl_negedge;
  logic       last_addr_bit_done, last_data_bit_done, SCL_d, next_byte;
  logic [3:0] state_out;
  logic [2:0] data_bit, addr_bit;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rdy_cnt = 0;
  logic [7:0] exp_data_out;
  logic [7:0] exp_q[$];

  assign SDA = m_oe ? 1'b0 : 1'bz;
  pullup (SDA);

  i2c_subordinate #(.SUB_ADDR(7'h01)) dut (
    .clk_400            (clk_400),
    .rst_n              (rst_n),
    .SCL                (scl),
    .SDA                (SDA),
    .data_in            (data_in),
    .data_out           (data_out),
    .next_byte_1        (next_byte_1),
    .data_ready         (data_ready),
    .rw                 (rw),
    .state_out          (state_out),
    .data_reg           (data_reg),
    .addr_reg           (addr_reg),
    .data_bit           (data_bit),
    .addr_bit           (addr_bit),
    .addr_match         (addr_match),
    .scl_posedge        (scl_posedge),
    .scl_negedge        (scl_negedge),
    .last_addr_bit_done (last_addr_bit_done),
    .last_data_bit_done (last_data_bit_done),
    .SCL_d              (SCL_d),
    .next_byte          (next_byte)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_400 = ~clk_400;

  always @(negedge clk_400) if (data_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;

  // ---------------- reference model ----------------
  function automatic logic model_ack(input logic [6:0] a);
    return (a == 7'h01);
  endfunction

  // ---------------- master driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_400);
  endtask

  task automatic bit_w(input logic b);
    m_oe = ~b; wait_cyc(2);
    scl = 1'b1; wait_cyc(4);
    scl = 1'b0; wait_cyc(2);
  endtask

  task automatic bit_r(output logic b);
    m_oe = 1'b0; wait_cyc(2);
    scl = 1'b1; wait_cyc(2);
    b = SDA; wait_cyc(2);
    scl = 1'b0; wait_cyc(2);
  endtask

  task automatic m_start();
    if (!scl) begin
      m_oe = 1'b0; wait_cyc(2);
      scl = 1'b1; wait_cyc(2);
    end
    m_oe = 1'b1; wait_cyc(4);
    scl = 1'b0; wait_cyc(2);
  endtask

  task automatic m_stop();
    m_oe = 1'b1; wait_cyc(2);
    scl = 1'b1; wait_cyc(4);
    m_oe = 1'b0; wait_cyc(4);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_w(v[i]);
    bit_r(b);
    ack = (b === 1'b0);
  endtask

  task automatic rd_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      v[i] = b;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b0; m_oe = 1'b0; data_in = 8'h00; next_byte_1 = 1'b0;
    exp_data_out = 8'h00;
    wait_cyc(3);
    n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_out); end
    n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want released(1)", SDA); end
    n_cmp++; if ({data_out, data_reg, addr_reg} !== 24'h0) begin n_bad++; $display("FAIL reset_regs: got %h want 000000", {data_out, data_reg, addr_reg}); end
    n_cmp++; if ({data_bit, addr_bit} !== 6'o77) begin n_bad++; $display("FAIL reset_bitidx: got %o want 77", {data_bit, addr_bit}); end
    n_cmp++;
    if ({data_ready, rw, addr_match, scl_posedge, scl_negedge, last_addr_bit_done, last_data_bit_done, SCL_d, next_byte} !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000000",
               {data_ready, rw, addr_match, scl_posedge, scl_negedge, last_addr_bit_done, last_data_bit_done, SCL_d, next_byte});
    end
    rst_n = 1'b1; wait_cyc(2);
    scl = 1'b1; wait_cyc(4);
    n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL idle_state: got %0d want 0", state_out); end
  endtask

  task automatic test_write();
    logic ack; logic [7:0] v; logic nb; int c0;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 8'hAB : 8'($urandom_range(0, 255));
      nb = 1'($urandom_range(0, 1));
      next_byte_1 = nb;
      c0 = rdy_cnt;
      m_start();
      wr_byte({7'h01, 1'b0}, ack);
      n_cmp++; if (ack !== model_ack(7'h01)) begin n_bad++; $display("FAIL write_addr_ack: got %b want 1", ack); end
      n_cmp++; if (rw !== 1'b0) begin n_bad++; $display("FAIL write_rw: got %b want 0", rw); end
      wr_byte(v, ack);
      exp_data_out = v;
      n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_data_ack: got %b want 1", ack); end
      n_cmp++; if (data_out !== exp_data_out) begin n_bad++; $display("FAIL write_data_out: got %h want %h", data_out, exp_data_out); end
      n_cmp++; if (rdy_cnt !== c0 + 1) begin n_bad++; $display("FAIL write_ready_pulses: got %0d want %0d", rdy_cnt - c0, 1); end
      n_cmp++; if (next_byte !== nb) begin n_bad++; $display("FAIL write_next_byte: got %b want %b", next_byte, nb); end
      m_stop();
      n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL write_stop_state: got %0d want 0", state_out); end
    end
  endtask

  task automatic test_read();
    logic ack; logic [7:0] v, e;
    for (int i = 0; i < 3; i++) begin
      data_in = (i == 0) ? 8'hC3 : 8'($urandom_range(0, 255));
      m_start();
      wr_byte({7'h01, 1'b1}, ack);
      exp_q.push_back(data_in);
      data_in = 8'($urandom_range(0, 255));
      n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL read_addr_ack: got %b want 1", ack); end
      n_cmp++; if (rw !== 1'b1) begin n_bad++; $display("FAIL read_rw: got %b want 1", rw); end
      rd_byte(v);
      e = exp_q.pop_front();
      n_cmp++; if (v !== e) begin n_bad++; $display("FAIL read_byte: got %h want %h", v, e); end
      bit_w(1'b1);
      n_cmp++; if (state_out !== 4'd7) begin n_bad++; $display("FAIL read_nack_state: got %0d want 7", state_out); end
      m_stop();
      n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL read_stop_state: got %0d want 0", state_out); end
      n_cmp++; if (data_out !== exp_data_out) begin n_bad++; $display("FAIL read_data_out_kept: got %h want %h", data_out, exp_data_out); end
    end
  endtask

  task automatic test_wrong_addr();
    logic ack; logic [6:0] a; int c0;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 7'h02 : 7'($urandom_range(2, 127));
      c0 = rdy_cnt;
      m_start();
      wr_byte({a, 1'($urandom_range(0, 1))}, ack);
      n_cmp++; if (ack !== model_ack(a)) begin n_bad++; $display("FAIL bad_addr_ack: addr %h got %b want %b", a, ack, model_ack(a)); end
      n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL bad_addr_state: got %0d want 0", state_out); end
      n_cmp++; if (addr_match !== 1'b0) begin n_bad++; $display("FAIL bad_addr_match: got %b want 0", addr_match); end
      m_stop();
      n_cmp++; if (data_out !== exp_data_out) begin n_bad++; $display("FAIL bad_addr_data_out: got %h want %h", data_out, exp_data_out); end
      n_cmp++; if (rdy_cnt !== c0) begin n_bad++; $display("FAIL bad_addr_ready: got %0d pulses want 0", rdy_cnt - c0); end
    end
  endtask

  task automatic test_read_multi();
    logic ack; logic [7:0] v, e;
    data_in = 8'($urandom_range(0, 255));
    m_start();
    wr_byte({7'h01, 1'b1}, ack);
    exp_q.push_back(data_in);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL multi_addr_ack: got %b want 1", ack); end
    for (int k = 0; k < 3; k++) begin
      rd_byte(v);
      e = exp_q.pop_front();
      n_cmp++; if (v !== e) begin n_bad++; $display("FAIL multi_read_byte%0d: got %h want %h", k, v, e); end
      if (k < 2) begin
        data_in = (k == 0) ? 8'h5A : 8'($urandom_range(0, 255));
        exp_q.push_back(data_in);
        bit_w(1'b0);
        data_in = 8'($urandom_range(0, 255));
      end else begin
        bit_w(1'b1);
      end
    end
    n_cmp++; if (state_out !== 4'd7) begin n_bad++; $display("FAIL multi_nack_state: got %0d want 7", state_out); end
    m_stop();
    n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL multi_stop_state: got %0d want 0", state_out); end
  endtask

  task automatic test_back_to_back();
    logic ack; logic [7:0] v, e; logic nb; int c0;
    c0 = rdy_cnt;
    m_start();
    wr_byte({7'h01, 1'b0}, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_addr_ack: got %b want 1", ack); end
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom_range(0, 255));
      nb = 1'($urandom_range(0, 1));
      next_byte_1 = nb;
      wr_byte(v, ack);
      exp_data_out = v;
      n_cmp++; if (ack !== 1'b1 || data_out !== exp_data_out) begin
        n_bad++; $display("FAIL b2b_write%0d: got ack=%b data=%h want ack=1 data=%h", k, ack, data_out, exp_data_out);
      end
      n_cmp++; if (next_byte !== nb) begin n_bad++; $display("FAIL b2b_next_byte%0d: got %b want %b", k, next_byte, nb); end
    end
    n_cmp++; if (rdy_cnt !== c0 + 3) begin n_bad++; $display("FAIL b2b_ready_pulses: got %0d want 3", rdy_cnt - c0); end
    data_in = 8'($urandom_range(0, 255));
    m_start();
    wr_byte({7'h01, 1'b1}, ack);
    exp_q.push_back(data_in);
    n_cmp++; if (ack !== 1'b1 || rw !== 1'b1) begin n_bad++; $display("FAIL rstart_addr: got ack=%b rw=%b want 1 1", ack, rw); end
    rd_byte(v);
    e = exp_q.pop_front();
    n_cmp++; if (v !== e) begin n_bad++; $display("FAIL rstart_read: got %h want %h", v, e); end
    bit_w(1'b1);
    m_stop();
    n_cmp++; if (state_out !== 4'd0 || data_out !== exp_data_out) begin
      n_bad++; $display("FAIL rstart_end: got state=%0d data=%h want 0 %h", state_out, data_out, exp_data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic ack; logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    m_start();
    wr_byte({7'h01, 1'b0}, ack);
    for (int b = 7; b >= 4; b--) bit_w(v[b]);
    n_cmp++; if (state_out !== 4'd3) begin n_bad++; $display("FAIL mid_rx_state: got %0d want 3", state_out); end
    rst_n = 1'b0; m_oe = 1'b0;
    #1;
    exp_data_out = 8'h00;
    n_cmp++; if (state_out !== 4'd0) begin n_bad++; $display("FAIL mid_reset_state: got %0d want 0", state_out); end
    n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL mid_reset_sda: got %b want 1", SDA); end
    n_cmp++; if (data_out !== exp_data_out || data_bit !== 3'd7) begin
      n_bad++; $display("FAIL mid_reset_regs: got data=%h bit=%0d want %h 7", data_out, data_bit, exp_data_out);
    end
    scl = 1'b1; wait_cyc(2);
    rst_n = 1'b1; wait_cyc(4);
    m_start();
    wr_byte({7'h01, 1'b0}, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL post_reset_addr_ack: got %b want 1", ack); end
    wr_byte(8'hAB, ack);
    exp_data_out = 8'hAB;
    n_cmp++; if (ack !== 1'b1 || data_out !== exp_data_out) begin
      n_bad++; $display("FAIL post_reset_write: got ack=%b data=%h want 1 %h", ack, data_out, exp_data_out);
    end
    m_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_read_multi();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_subordinate.md
Name: i2c_subordinate

Overview:
I2C target (subordinate) with a fixed 7-bit address. It sits on the shared SCL/SDA open-drain bus next to the codebase's I2C master, and both run from the same clk_400 clock. It receives single bytes on writes and returns a host-supplied byte on reads. Internal state is exported on debug ports for bench visibility.

Parameters:
SUB_ADDR, 7'h01, own 7-bit bus address; only this address is ACKed.

Ports:
clk_400  in  1  system clock; samples SCL/SDA.
rst_n  in  1  asynchronous active-low reset.
SCL  in  1  bus clock driven by the master.
SDA  inout  1  open-drain data line; drive 0 or Z only, external pullup.
data_in  in  8  byte returned to the master on a read; sampled at the address-ACK.
data_out  out  8  last byte received on a write.
next_byte_1  in  1  master continuation hint; latched at each data ACK.
data_ready  out  1  one-cycle pulse when data_out updates.
rw  out  1  R/W bit of the current transaction (1 = read).
state_out  out  4  current FSM state encoding.
data_reg  out  8  data shift register.
addr_reg  out  8  address shift register, {addr[6:0], rw}.
data_bit  out  3  data bit index, 7..0.
addr_bit  out  3  address bit index, 7..0.
addr_match  out  1  addr_reg[7:1] == SUB_ADDR; valid after the 8th address bit.
scl_posedge, scl_negedge  out  1  single-cycle SCL edge strobes.
last_addr_bit_done, last_data_bit_done  out  1  pulse when bit 0 is sampled or shifted.
SCL_d  out  1  SCL registered by one clk_400 cycle.
next_byte  out  1  latched copy of next_byte_1.

Behaviour:
- Reset (async, rst_n=0) forces the following:
  - State IDLE (0) and SDA released (Z).
  - All outputs 0, except data_bit and addr_bit, which reset to 7.
- Edge detection:
  - SCL_d <= SCL on every clk_400 edge.
  - scl_posedge = SCL & ~SCL_d; scl_negedge = ~SCL & SCL_d.
  - SDA_d is registered the same way.
- START is SDA falling while SCL=1. From any state it moves the FSM to ADDR (1), sets addr_bit=7 and releases SDA. A repeated START is handled identically.
- STOP is SDA rising while SCL=1. From any state it moves the FSM to IDLE and releases SDA.
- SDA sampling and driving:
  - Sample SDA only on scl_posedge.
  - Change the SDA drive only on the cycle where scl_negedge is seen, so SDA is stable while SCL is high.
- ADDR (1):
  - Shift SDA into addr_reg LSB-first-shift (MSB received first) and decrement addr_bit.
  - On the 8th bit, pulse last_addr_bit_done, compute addr_match and latch rw = bit 0.
  - On match, go to ADDR_ACK (2). On mismatch, go to IDLE without driving SDA, so the master sees a NACK.
- ADDR_ACK (2):
  - Drive SDA=0 at the next scl_negedge and hold it through the ACK-clock high phase.
  - At the following negedge, release SDA.
  - If rw=0, go to RX (3) with data_bit=7.
  - If rw=1, load data_reg from data_in, drive data_reg[7] and go to TX (5).
- RX (3):
  - Shift SDA into data_reg on each posedge.
  - After bit 0, pulse last_data_bit_done, copy data_reg to data_out, pulse data_ready for 1 cycle, and go to RX_ACK (4).
- RX_ACK (4):
  - Drive ACK as in ADDR_ACK and latch next_byte.
  - At the negedge ending the ACK, release SDA and return to RX for another byte.
  - A STOP returns the FSM to IDLE.
- TX (5):
  - On each negedge, shift and present the next bit MSB-first.
  - After bit 0, pulse last_data_bit_done, release SDA at the negedge and go to TX_ACK (6).
- TX_ACK (6):
  - Sample the master's ACK on the posedge.
  - ACK (SDA=0): reload data_reg from data_in and continue TX.
  - NACK (SDA=1): go to WAIT_STOP (7) with SDA released.
- data_out holds its value until the next completed write byte; it is unaffected by reads and by NACKed addresses.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7), shared with the master;
  - the default address constant.
- Optional sub-module i2c_bus_sync: registers SCL/SDA and produces the edge strobes plus START/STOP detection.

Test Plan:
- Reset then idle bus → all outputs 0, SDA=Z, state_out=0.
- Master writes 0xAB to address 0x01 → address ACKed, data_ready pulses once, data_out=0xAB, rw=0, master ack_error=0.
- Master reads address 0x01 with data_in=0xC3 → rw=1, master data_out=0xC3, master done=1, ack_error=0.
- Master writes to address 0x02 → no ACK, master ack_error=1, data_out unchanged, state returns to IDLE.
- Read with master ACK after the first byte, data_in changed to 0x5A → second byte 0x5A is sent; NACK then STOP → IDLE.
- rst_n asserted mid-byte during RX → immediate IDLE, SDA released; the next full write of 0xAB succeeds.
